conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//  Raster pixel stream -> 3x3 sliding-window generator; the producer end of the convolution datapath.
//  Accepts one NBITS pixel per valid/ready handshake and buffers two image lines internally.
//  Emits one packConv::param9 window per valid output position ("valid" convolution, no padding).
//  Output feeds the 3x3 MAC/CSA tree, which consumes param9 operands.
// PARAMETERS
//  IMG_W   16  image width in pixels (>=3); sets line-buffer depth
//  IMG_H   16  image height in lines (>=3)
//  NBITS   (packConv::NBITS = 20) pixel width; not overridable
// PORTS
//  clock        in   1          single clock, rising edge
//  reset        in   1          synchronous, active-high
//  start        in   1          1-cycle pulse: begin new frame (ignored unless IDLE or DONE)
//  pix_in       in   NBITS      input pixel, raster order
//  pix_valid    in   1          pix_in valid
//  pix_ready    out  1          block accepts pix_in this cycle
//  window       out  9*NBITS    packConv::param9; [0]=top-left ... [8]=bottom-right, row-major
//  win_valid    out  1          window valid
//  win_ready    in   1          consumer accepts window
//  win_last     out  1          qualifies final window of frame
//  busy         out  1          high in FILL/STREAM
// BEHAVIOUR
//  Reset: pix_ready=0, win_valid=0, win_last=0, busy=0, window='0, counters=0, state=IDLE.
//  FSM: IDLE -start-> FILL; FILL -(row==2 && col==2 accepted)-> STREAM;
//    STREAM -(last pixel row IMG_H-1,col IMG_W-1 accepted)-> DONE;
//    DONE -(win_last handshake)-> IDLE; DONE -start-> FILL only after last handshake.
//  Pixel accept: pix_valid && pix_ready; pix_ready = (FILL|STREAM) && (!win_valid || win_ready).
//  Counters col 0..IMG_W-1, row 0..IMG_H-1; col wraps to 0 and row increments on col==IMG_W-1.
//  Line buffers: two IMG_W-deep FIFOs (line-1, line-2), written on every accepted pixel.
//  3x3 shift register: shifts on every accepted pixel, including cols 0..1 (no window emitted).
//  Window emitted for accepted pixel at (row>=2, col>=2); covers rows row-2..row, cols col-2..col.
//  Latency: window registered; win_valid rises cycle after accepting completing pixel.
//  Output hold: window/win_valid/win_last stable while win_valid && !win_ready.
//  Simultaneous win handshake + new completing pixel: win_valid stays 1, window updates (no bubble).
//  Windows per frame: (IMG_W-2)*(IMG_H-2); win_last=1 only with the final one.
//  start during FILL/STREAM ignored; pix_valid in IDLE/DONE ignored (pix_ready=0).
//  Reset mid-frame: all state to reset values next edge; partial window discarded.
//  No arithmetic on pixel data; pure data movement, widths preserved bit-exact.
// CONFIGURATION
//  WIN_COUNT_EN defined:
//   extra outputs win_count[15:0] (windows handshaken this frame, cleared on start/reset)
//   and frame_done (1-cycle pulse cycle after win_last handshake, reset 0).
//  WIN_COUNT_EN undefined: ports absent; no counter logic; all other behaviour identical.
// TESTING
//  IMG_W=4,IMG_H=4, pixels 0..15, win_ready=1 -> 4 windows: {0,1,2,4,5,6,8,9,10},
//   {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}; last has win_last=1.
//  Same frame, win_valid cycle after pixel 10 accepted; none during pixels 0..9 -> exact latency.
//  win_ready=0 for 5 cycles at first window -> window held stable, pix_ready=0, no pixel lost.
//  Default 16x16, random pix_valid/win_ready gaps -> 196 windows, match golden model, single win_last.
//  reset after pixel 7 of frame, then start + full frame 100..115 -> windows only from new data.
//  WIN_COUNT_EN, 4x4 frame -> win_count=4 and frame_done pulse once; start clears to 0.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: converts a raster pixel stream into 3x3 sliding windows
// ("valid" convolution, no padding) for the downstream 3x3 MAC/CSA tree.
// Two image lines are held in internal line buffers. The 3x3 window register
// shifts on every accepted pixel and is presented directly as the output.
// Optional build macro: WIN_COUNT_EN adds the win_count and frame_done outputs.

package packConv;
    localparam int NBITS = 20;
    // Nine pixels, row-major: [0] = top-left ... [8] = bottom-right.
    typedef logic [8:0][NBITS-1:0] param9;
endpackage

module conv_window_gen
    import packConv::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output param9            window,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             win_last,
    output logic             busy
`ifdef WIN_COUNT_EN
    ,
    output logic [15:0]      win_count,
    output logic             frame_done
`endif
);

    localparam int            CW       = $clog2(IMG_W);
    localparam int            RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [NBITS-1:0]  r_line1 [IMG_W];
    logic [NBITS-1:0]  r_line2 [IMG_W];
    param9             r_sr;
    logic              r_win_valid;
    logic              r_win_last;

    logic              w_in_frame;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_end;
    logic              w_emit;
    logic              w_win_hs;
    logic              w_last_hs;
    logic              w_start_frame;
    logic [NBITS-1:0]  w_top;
    logic [NBITS-1:0]  w_mid;

    assign w_accept      = pix_valid && pix_ready;
    assign w_col_last    = (r_col == COL_LAST);
    assign w_row_last    = (r_row == ROW_LAST);
    assign w_frame_end   = w_accept && w_col_last && w_row_last;
    assign w_emit        = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_win_hs      = r_win_valid && win_ready;
    assign w_last_hs     = w_win_hs && r_win_last;
    // A new frame may only begin once the previous frame's last window has left.
    assign w_start_frame = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && w_last_hs));

    // Pixels from one and two lines above at the current column.
    assign w_top = r_line2[r_col];
    assign w_mid = r_line1[r_col];

    // State register.
    // NOTE: clocked state is always written with <= so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_frame) w_next_state = S_FILL;
            end
            S_FILL: begin
                // A 3x3 image completes its only window in the fill phase.
                if (w_frame_end) begin
                    w_next_state = S_DONE;
                end else if (w_accept && (r_row == ROW_TWO) && (r_col == COL_TWO)) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_frame_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_start_frame) begin
                    w_next_state = S_FILL;
                end else if (w_last_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; input is stalled while an unconsumed window is held.
    always_comb begin
        w_in_frame = (r_state == S_FILL) || (r_state == S_STREAM);
        busy       = w_in_frame;
        pix_ready  = w_in_frame && (!r_win_valid || win_ready);
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_frame) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers: each column slot ages one line per accepted pixel.
    // NOTE: the line-buffer storage has no reset. Windows are only emitted from
    // row 2 onward, by which point every slot read has been rewritten this frame.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_line2[r_col] <= r_line1[r_col];
            r_line1[r_col] <= pix_in;
        end
    end

    // 3x3 window register: shift left one column and load the new right column.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sr <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_sr[r*3 + 0] <= r_sr[r*3 + 1];
                r_sr[r*3 + 1] <= r_sr[r*3 + 2];
            end
            r_sr[2] <= w_top;
            r_sr[5] <= w_mid;
            r_sr[8] <= pix_in;
        end
    end

    // Window qualifiers: set by a completing pixel, cleared by a consumer handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_last  <= w_frame_end;
        end else if (w_win_hs) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end
    end

    // The shift register only moves on accept, and accept is blocked while a
    // window waits on the consumer, so it doubles as the held output register.
    assign window    = r_sr;
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

`ifdef WIN_COUNT_EN
    logic [15:0] r_win_count;
    logic        r_frame_done;

    // Windows handed to the consumer in the current frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_count <= '0;
        end else if (w_start_frame) begin
            r_win_count <= '0;
        end else if (w_win_hs) begin
            r_win_count <= r_win_count + 16'd1;
        end
    end

    // One-cycle pulse following the final window handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_hs;
        end
    end

    assign win_count  = r_win_count;
    assign frame_done = r_frame_done;
`endif

endmodule
